fpu_round: RTL and testbench
============================

# fpu_round

Rounding and packing stage of the double-precision add path. Consumes the pre-rounded magnitude produced by the adder stage: sign, 56-bit aligned sum, 11-bit exponent and alignment sticky. Applies one of four IEEE-754 rounding modes, handles mantissa carry-out, denormal-to-normal promotion and exponent overflow, and emits the packed 64-bit result with inexact/overflow flags. It is a 3-stage pipeline gated by the same `enable` as the adder.

## Interface

- No parameters; format fixed at binary64.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  pipeline advance; all registers hold when low.
- in_valid  in  1  qualifies the input bundle this cycle.
- rmode  in  2  rounding mode:
  - 00 nearest-even
  - 01 toward zero
  - 10 toward +inf
  - 11 toward -inf
- sign  in  1  result sign.
- sum_2  in  56  bit 55 = 0; bit 54 = hidden bit; bits 53:2 = fraction; bit 1 = guard; bit 0 = round.
- exponent_2  in  11  biased exponent; 0 with bit54=0 means denormal; 2047 means already overflowed.
- shift_inexact  in  1  bits lost during alignment (sticky).
- out  out  64  packed result {sign, exp[10:0], frac[51:0]}.
- out_valid  out  1  `out` and flags valid.
- inexact  out  1  result differs from exact value.
- overflow  out  1  result exceeded max finite.

## Operation

- Stage 1 (register + decide):
  - Capture inputs, rmode and in_valid.
  - lsb = sum_2[2]; guard = sum_2[1]; sticky = sum_2[0] | shift_inexact.
  - round_up by mode:
    - RNE: guard & (sticky | lsb)
    - RTZ: 0
    - RUP: (guard | sticky) & !sign
    - RDN: (guard | sticky) & sign
  - inexact_1 = guard | sticky.
- Stage 2 (increment):
  - m[53:0] = {1'b0, sum_2[54:2]} + round_up.
  - If m[53]: frac = 0 and exp = exponent_2 + 1 (12-bit add).
  - Else if exponent_2 == 0 and m[52]: exp = 1 (denormal rounded up to min normal); frac = m[51:0].
  - Else exp = exponent_2; frac = m[51:0].
- Stage 3 (overflow + pack):
  - If exp ≥ 2047 (including input exponent_2 == 2047), overflow = 1 and inexact = 1. Result depends on mode:
    - RNE: ±inf.
    - RTZ: ±max finite (exp 0x7FE, frac all ones).
    - RUP: +inf if sign = 0; -max if sign = 1.
    - RDN: -inf if sign = 1; +max if sign = 0.
  - Otherwise out = {sign, exp[10:0], frac}; overflow = 0; inexact = inexact_1.
- NaN/inf operand handling and the zero-sign rule are upstream's responsibility. The sign passes through unchanged.
- Flags and out are updated every enabled cycle. Consumers sample them only with out_valid.

## Timing

- Latency is 3 enabled cycles from input capture to out_valid. Throughput is 1 per enabled cycle, with no bubbles.
- out_valid is in_valid delayed through 3 enable-gated flops.
- enable low: every stage, including the valid chain and outputs, holds its value. No data is dropped or duplicated.
- rst: all registers clear on the next edge. out = 0, out_valid = 0, inexact = 0, overflow = 0. rst takes priority over enable.
- Reset mid-flight discards all in-flight results. The first valid after reset appears 3 enabled cycles after a new in_valid.
- Inputs with in_valid = 0 still propagate, but out_valid stays 0.

## Test plan

- Exact value, RNE: sign = 0, exponent_2 = 0x3FF, sum_2 = 0x40000000000000, shift_inexact = 0.
  - Required: after 3 cycles, out = 0x3FF0000000000000, inexact = 0, overflow = 0.
- Tie handling, RNE:
  - sum_2 = 0x40000000000002 (tie, lsb 0) -> out = 0x3FF0000000000000, inexact = 1.
  - sum_2 = 0x40000000000006 (tie, lsb 1) -> out = 0x3FF0000000000002, inexact = 1.
- Directed rounding and carry:
  - RDN, sign = 1, sum_2 = 0x40000000000000, shift_inexact = 1 -> out = 0xBFF0000000000001, inexact = 1.
  - RNE, exp = 0x3FF, sum_2 = 0x7FFFFFFFFFFFFE -> out = 0x4000000000000000.
- Overflow and denormal promotion:
  - exp = 0x7FE, sum_2 = 0x7FFFFFFFFFFFFE, RNE -> out = 0x7FF0000000000000, overflow = 1, inexact = 1.
  - exponent_2 = 0x7FF, RTZ, sign = 0 -> out = 0x7FEFFFFFFFFFFFFF, overflow = 1.
  - exp = 0, sum_2 = 0x3FFFFFFFFFFFFE, RNE -> out = 0x0010000000000000.
- Pipelining, stall and reset:
  - Stimulus: 5 back-to-back valid inputs with enable low for 2 cycles mid-stream.
  - Required: 5 results in order, each valid for exactly one enabled cycle, outputs held during the stall.
  - Then assert rst with 2 results in flight. Required: out_valid = 0 the next cycle and no stale result ever emerges.

Source files
------------

// File: rtl/fpu_round_if.sv
// rtl/fpu_round_if.sv - operand/result bundle for the binary64 rounding stage
//
// Groups the pipeline-advance control, the pre-rounded operand bundle from the
// adder stage and the packed result/flags of fpu_round.
//   enable        pipeline advance; every register holds while low
//   in_valid      qualifies the operand bundle this cycle
//   rmode         00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
//   sign          result sign
//   sum_2         {0, hidden, fraction[51:0], guard, round}
//   exponent_2    biased exponent (2047 = already overflowed)
//   shift_inexact sticky of bits lost during alignment
//   out           packed result {sign, exp[10:0], frac[51:0]}
//   out_valid     out and flags valid
//   inexact       result differs from exact value
//   overflow      result exceeded max finite
// master: producer/consumer side; slave: the rounding stage.

interface fpu_round_if;
    logic        enable;
    logic        in_valid;
    logic [1:0]  rmode;
    logic        sign;
    logic [55:0] sum_2;
    logic [10:0] exponent_2;
    logic        shift_inexact;
    logic [63:0] out;
    logic        out_valid;
    logic        inexact;
    logic        overflow;

    modport master (
        output enable, in_valid, rmode, sign, sum_2, exponent_2, shift_inexact,
        input  out, out_valid, inexact, overflow
    );

    modport slave (
        input  enable, in_valid, rmode, sign, sum_2, exponent_2, shift_inexact,
        output out, out_valid, inexact, overflow
    );
endinterface

// File: rtl/fpu_round.sv
// rtl/fpu_round.sv - 3-stage binary64 rounding and packing pipeline
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset, takes priority over enable
//   bus  fpu_round_if.slave (operand bundle in, packed result and flags out)
// Stage 1 captures the operand and decides the rounding increment, stage 2
// applies it (carry-out and denormal promotion), stage 3 saturates on
// exponent overflow according to the mode and packs the result.

module fpu_round (
    input  logic         clk,
    input  logic         rst,
    fpu_round_if.slave   bus
);

    localparam logic [1:0]  RM_RNE = 2'b00;
    localparam logic [1:0]  RM_RTZ = 2'b01;
    localparam logic [1:0]  RM_RUP = 2'b10;
    localparam logic [1:0]  RM_RDN = 2'b11;

    localparam logic [10:0] EXP_INF  = 11'h7FF;
    localparam logic [10:0] EXP_MAX  = 11'h7FE;
    localparam logic [51:0] FRAC_MAX = {52{1'b1}};

    // ------------------------------------------------------------------
    // Stage 1: capture and rounding decision
    // ------------------------------------------------------------------
    logic        lsb_in;
    logic        guard_in;
    logic        sticky_in;
    logic        round_up_in;

    assign lsb_in    = bus.sum_2[2];
    assign guard_in  = bus.sum_2[1];
    assign sticky_in = bus.sum_2[0] | bus.shift_inexact;

    always_comb begin
        round_up_in = 1'b0;
        unique case (bus.rmode)
            RM_RNE:  round_up_in = guard_in & (sticky_in | lsb_in);
            RM_RTZ:  round_up_in = 1'b0;
            RM_RUP:  round_up_in = (guard_in | sticky_in) & ~bus.sign;
            RM_RDN:  round_up_in = (guard_in | sticky_in) & bus.sign;
            default: round_up_in = 1'b0;
        endcase
    end

    logic        s1_valid_q,    s1_valid_d;
    logic        s1_sign_q,     s1_sign_d;
    logic [1:0]  s1_rmode_q,    s1_rmode_d;
    logic [52:0] s1_mant_q,     s1_mant_d;
    logic [10:0] s1_exp_q,      s1_exp_d;
    logic        s1_round_up_q, s1_round_up_d;
    logic        s1_inexact_q,  s1_inexact_d;

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_sign_d     = s1_sign_q;
        s1_rmode_d    = s1_rmode_q;
        s1_mant_d     = s1_mant_q;
        s1_exp_d      = s1_exp_q;
        s1_round_up_d = s1_round_up_q;
        s1_inexact_d  = s1_inexact_q;
        if (bus.enable) begin
            s1_valid_d    = bus.in_valid;
            s1_sign_d     = bus.sign;
            s1_rmode_d    = bus.rmode;
            s1_mant_d     = bus.sum_2[54:2];
            s1_exp_d      = bus.exponent_2;
            s1_round_up_d = round_up_in;
            s1_inexact_d  = guard_in | sticky_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_rmode_q    <= 2'b00;
            s1_mant_q     <= '0;
            s1_exp_q      <= '0;
            s1_round_up_q <= 1'b0;
            s1_inexact_q  <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_rmode_q    <= s1_rmode_d;
            s1_mant_q     <= s1_mant_d;
            s1_exp_q      <= s1_exp_d;
            s1_round_up_q <= s1_round_up_d;
            s1_inexact_q  <= s1_inexact_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: increment, carry-out renormalisation, denormal promotion
    // ------------------------------------------------------------------
    logic [53:0] m_inc;
    logic [11:0] exp_rnd;
    logic [51:0] frac_rnd;

    assign m_inc = {1'b0, s1_mant_q} + {53'd0, s1_round_up_q};

    always_comb begin
        exp_rnd  = {1'b0, s1_exp_q};
        frac_rnd = m_inc[51:0];
        if (m_inc[53]) begin
            // 1.111..1 + ulp = 10.000..0: fraction clears, exponent bumps.
            // 12 bits so that 2046 + 1 and 2047 + 1 are both seen as overflow.
            exp_rnd  = {1'b0, s1_exp_q} + 12'd1;
            frac_rnd = '0;
        end else if (s1_exp_q == 11'd0 && m_inc[52]) begin
            // Largest denormal rounded up into the smallest normal.
            exp_rnd  = 12'd1;
        end
    end

    logic        s2_valid_q,   s2_valid_d;
    logic        s2_sign_q,    s2_sign_d;
    logic [1:0]  s2_rmode_q,   s2_rmode_d;
    logic [11:0] s2_exp_q,     s2_exp_d;
    logic [51:0] s2_frac_q,    s2_frac_d;
    logic        s2_inexact_q, s2_inexact_d;

    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_sign_d    = s2_sign_q;
        s2_rmode_d   = s2_rmode_q;
        s2_exp_d     = s2_exp_q;
        s2_frac_d    = s2_frac_q;
        s2_inexact_d = s2_inexact_q;
        if (bus.enable) begin
            s2_valid_d   = s1_valid_q;
            s2_sign_d    = s1_sign_q;
            s2_rmode_d   = s1_rmode_q;
            s2_exp_d     = exp_rnd;
            s2_frac_d    = frac_rnd;
            s2_inexact_d = s1_inexact_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_rmode_q   <= 2'b00;
            s2_exp_q     <= '0;
            s2_frac_q    <= '0;
            s2_inexact_q <= 1'b0;
        end else begin
            s2_valid_q   <= s2_valid_d;
            s2_sign_q    <= s2_sign_d;
            s2_rmode_q   <= s2_rmode_d;
            s2_exp_q     <= s2_exp_d;
            s2_frac_q    <= s2_frac_d;
            s2_inexact_q <= s2_inexact_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: overflow saturation and packing
    // ------------------------------------------------------------------
    logic        exp_ovf;
    logic [63:0] packed_res;
    logic [63:0] inf_res;
    logic [63:0] max_res;

    assign exp_ovf = (s2_exp_q >= 12'd2047);
    assign inf_res = {s2_sign_q, EXP_INF, 52'd0};
    assign max_res = {s2_sign_q, EXP_MAX, FRAC_MAX};

    always_comb begin
        packed_res = {s2_sign_q, s2_exp_q[10:0], s2_frac_q};
        if (exp_ovf) begin
            // Round toward infinity only when the mode points away from zero
            // for this sign; otherwise clamp at the largest finite magnitude.
            unique case (s2_rmode_q)
                RM_RNE:  packed_res = inf_res;
                RM_RTZ:  packed_res = max_res;
                RM_RUP:  packed_res = s2_sign_q ? max_res : inf_res;
                RM_RDN:  packed_res = s2_sign_q ? inf_res : max_res;
                default: packed_res = inf_res;
            endcase
        end
    end

    logic [63:0] out_q,       out_d;
    logic        out_valid_q, out_valid_d;
    logic        inexact_q,   inexact_d;
    logic        overflow_q,  overflow_d;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        inexact_d   = inexact_q;
        overflow_d  = overflow_q;
        if (bus.enable) begin
            out_d       = packed_res;
            out_valid_d = s2_valid_q;
            inexact_d   = s2_inexact_q | exp_ovf;
            overflow_d  = exp_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            inexact_q   <= inexact_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.inexact   = inexact_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fpu_round.sv
// tb/tb_fpu_round.sv - self-checking bench for the binary64 rounding pipeline

module tb_fpu_round;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_round_if bus();

    fpu_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        sgn;
        logic [1:0]  rm;
        logic [55:0] s;
        logic [10:0] e;
        logic        sti;
        logic [63:0] xo;
        logic        xi;
        logic        xv;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    // Value-level model: the operand is mant + rem/4 ulp, where rem folds the
    // guard bit and everything below it (round bit, alignment sticky).
    function automatic logic [65:0] model(input logic sgn, input logic [1:0] rm,
                                          input logic [55:0] s, input logic [10:0] e,
                                          input logic sti);
        longint unsigned mant;
        int              rem;
        int              ex;
        logic            up;
        logic            inx;
        logic [63:0]     res;
        logic [63:0]     maxv;
        logic [63:0]     infv;
        mant = 64'(s[54:2]);
        rem  = (s[1] ? 2 : 0) + ((s[0] | sti) ? 1 : 0);
        inx  = (rem != 0);
        case (rm)
            2'b00:   up = (rem > 2) || (rem == 2 && (mant % 2 == 1));
            2'b01:   up = 1'b0;
            2'b10:   up = (rem != 0) && !sgn;
            default: up = (rem != 0) && sgn;
        endcase
        if (up) mant = mant + 1;
        ex = int'(e);
        if (mant >= (64'd1 << 53)) begin
            mant = mant - (64'd1 << 53);
            ex   = ex + 1;
        end else if (ex == 0 && mant >= (64'd1 << 52)) begin
            ex = 1;
        end
        if (ex >= 2047) begin
            infv = {sgn, 11'h7FF, 52'd0};
            maxv = {sgn, 11'h7FE, {52{1'b1}}};
            case (rm)
                2'b00:   res = infv;
                2'b01:   res = maxv;
                2'b10:   res = sgn ? maxv : infv;
                default: res = sgn ? infv : maxv;
            endcase
            return {1'b1, 1'b1, res};
        end
        res = {sgn, 11'(ex), 52'(mant % (64'd1 << 52))};
        return {1'b0, inx, res};
    endfunction

    // Scoreboard: expected results pushed on each enabled capture, popped when
    // a fresh out_valid appears (i.e. after an enabled edge).
    logic [65:0] expq [$];
    logic [65:0] cur;
    logic        cur_ok = 1'b0;
    bit          fresh  = 1'b0;
    int          n_out  = 0;

    always @(posedge clk) begin
        if (rst) begin
            expq.delete();
            fresh = 1'b0;
        end else if (bus.enable) begin
            fresh = 1'b1;
            if (bus.in_valid)
                expq.push_back(model(bus.sign, bus.rmode, bus.sum_2, bus.exponent_2, bus.shift_inexact));
        end else begin
            fresh = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (fresh) begin
                fresh = 1'b0;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    cur_ok = 1'b0;
                    $display("FAIL unexpected_valid out=%h expected no result", bus.out);
                end else begin
                    cur    = expq.pop_front();
                    cur_ok = 1'b1;
                    n_out++;
                end
            end
            if (cur_ok) begin
                checks++;
                if ({bus.overflow, bus.inexact, bus.out} !== cur) begin
                    failures++;
                    $display("FAIL result ovf/inx/out got=%b/%b/%h want=%b/%b/%h",
                             bus.overflow, bus.inexact, bus.out, cur[65], cur[64], cur[63:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input int i, input logic v);
        bus.in_valid      = v;
        bus.sign          = vt[i].sgn;
        bus.rmode         = vt[i].rm;
        bus.sum_2         = vt[i].s;
        bus.exponent_2    = vt[i].e;
        bus.shift_inexact = vt[i].sti;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [65:0] m;
        int          n0;

        vt[0]  = '{1'b0, 2'b00, 56'h40000000000000, 11'h3FF, 1'b0, 64'h3FF0000000000000, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 2'b00, 56'h40000000000002, 11'h3FF, 1'b0, 64'h3FF0000000000000, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 2'b00, 56'h40000000000006, 11'h3FF, 1'b0, 64'h3FF0000000000002, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 2'b11, 56'h40000000000000, 11'h3FF, 1'b1, 64'hBFF0000000000001, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 2'b00, 56'h7FFFFFFFFFFFFE, 11'h3FF, 1'b0, 64'h4000000000000000, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 2'b00, 56'h7FFFFFFFFFFFFE, 11'h7FE, 1'b0, 64'h7FF0000000000000, 1'b1, 1'b1};
        vt[6]  = '{1'b0, 2'b01, 56'h40000000000000, 11'h7FF, 1'b0, 64'h7FEFFFFFFFFFFFFF, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 2'b00, 56'h3FFFFFFFFFFFFE, 11'h000, 1'b0, 64'h0010000000000000, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 2'b10, 56'h40000000000001, 11'h3FF, 1'b0, 64'h3FF0000000000001, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 2'b10, 56'h40000000000000, 11'h7FF, 1'b0, 64'hFFEFFFFFFFFFFFFF, 1'b1, 1'b1};
        vt[10] = '{1'b0, 2'b11, 56'h40000000000000, 11'h7FF, 1'b0, 64'h7FEFFFFFFFFFFFFF, 1'b1, 1'b1};
        vt[11] = '{1'b1, 2'b11, 56'h40000000000000, 11'h7FF, 1'b0, 64'hFFF0000000000000, 1'b1, 1'b1};
        vt[12] = '{1'b0, 2'b01, 56'h40000000000003, 11'h3FF, 1'b0, 64'h3FF0000000000000, 1'b1, 1'b0};
        vt[13] = '{1'b1, 2'b00, 56'h40000000000003, 11'h3FF, 1'b0, 64'hBFF0000000000001, 1'b1, 1'b0};
        vt[14] = '{1'b0, 2'b00, 56'h00000000000014, 11'h000, 1'b0, 64'h0000000000000005, 1'b0, 1'b0};
        vt[15] = '{1'b1, 2'b00, 56'h7FFFFFFFFFFFFE, 11'h7FE, 1'b0, 64'hFFF0000000000000, 1'b1, 1'b1};

        // Pin the model to the hand-computed literals.
        for (int i = 0; i < NV; i++) begin
            m = model(vt[i].sgn, vt[i].rm, vt[i].s, vt[i].e, vt[i].sti);
            check($sformatf("model_vec%0d", i), {62'd0, m[65:64]}, {62'd0, vt[i].xv, vt[i].xi});
            check($sformatf("model_out%0d", i), m[63:0], vt[i].xo);
        end

        // Reset state.
        rst = 1'b1;
        bus.enable = 1'b1;
        drive(0, 1'b0);
        step();
        step();
        check("reset_out",       bus.out, 64'd0);
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_inexact",   {63'd0, bus.inexact}, 64'd0);
        check("reset_overflow",  {63'd0, bus.overflow}, 64'd0);
        rst = 1'b0;

        // Back-to-back directed vectors.
        for (int i = 0; i < NV; i++) begin
            drive(i, 1'b1);
            step();
        end
        drive(0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("stream_count", 64'(n_out), 64'(NV));

        // Five valid inputs with a two-cycle stall while results are emerging.
        n0 = n_out;
        drive(2, 1'b1); step();
        drive(4, 1'b1); step();
        drive(5, 1'b1); step();
        check("pre_stall_valid", {63'd0, bus.out_valid}, 64'd1);
        drive(9, 1'b1);
        bus.enable = 1'b0;
        step();
        check("stall_valid_held", {63'd0, bus.out_valid}, 64'd1);
        check("stall_out_held", bus.out, vt[2].xo);
        step();
        check("stall_count", 64'(n_out - n0), 64'd1);
        bus.enable = 1'b1;
        step();
        drive(13, 1'b1); step();
        drive(0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("stall_results", 64'(n_out - n0), 64'd5);

        // Reset with two results in flight.
        n0 = n_out;
        drive(7, 1'b1); step();
        drive(11, 1'b1); step();
        drive(0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        for (int i = 0; i < 6; i++) step();
        check("flush_no_stale", 64'(n_out - n0), 64'd0);

        // First result after reset needs exactly three enabled edges.
        drive(3, 1'b1); step();
        drive(0, 1'b0); step();
        check("post_rst_lat2", {63'd0, bus.out_valid}, 64'd0);
        step();
        check("post_rst_lat3", {63'd0, bus.out_valid}, 64'd1);
        check("post_rst_out", bus.out, vt[3].xo);
        step();
        check("post_rst_single", {63'd0, bus.out_valid}, 64'd0);
        check("post_rst_count", 64'(n_out - n0), 64'd1);
        check("queue_drained", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
